// File: rtl/apb_cmd_master_pkg.sv
// Shared APB definitions: transfer-state encoding and default bus widths,
// used by the command master and the register-map slaves.
package apb_cmd_master_pkg;

  localparam int APB_ADDR_W = 12;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // Counter width able to hold 0..t, at least one bit.
  function automatic int cnt_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command/response handshake plus APB4 request/completion signals,
// seen from the command master (master) or from host+slave side (slave).
interface apb_cmd_master_if
  import apb_cmd_master_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [DATA_W/8-1:0]   cmd_strb;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic                  pwrite;
  logic [DATA_W/8-1:0]   pstrb;
  logic                  psel;
  logic                  penable;
  logic                  pready;
  logic                  pslverr;
  logic [DATA_W-1:0]     prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
           pready, pslverr, prdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           paddr, pwdata, pwrite, pstrb, psel, penable
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
           pready, pslverr, prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           paddr, pwdata, pwrite, pstrb, psel, penable
  );
endinterface

// File: rtl/apb_cmd_master_wait_timer.sv
// Counts ACCESS wait cycles; expired_o fires on the wait cycle that would
// reach TIMEOUT. TIMEOUT=0 disables the abort.
module apb_cmd_master_wait_timer
  import apb_cmd_master_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic prstn,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int             CW   = cnt_width(TIMEOUT);
  localparam logic [CW-1:0]  LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT != 0) && enable_i && (cnt_q == LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// Single-beat command to APB4 transfer bridge: IDLE->SETUP->ACCESS->RESP,
// every bus and response output driven straight from a flop.
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                  pclk,
  input  logic                  prstn,
  apb_cmd_master_if.master      bus
);
  localparam int STRB_W = DATA_W / 8;

  apb_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                pwrite_q, pwrite_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                accept;
  logic                wait_en;
  logic                expired;

  assign accept  = (state_q == ST_IDLE) && cmd_ready_q && bus.cmd_valid;
  assign wait_en = (state_q == ST_ACCESS) && !bus.pready;

  apb_cmd_master_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .pclk      (pclk),
    .prstn     (prstn),
    .clear_i   (accept),
    .enable_i  (wait_en),
    .expired_o (expired)
  );

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    pstrb_d     = pstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_SETUP;
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
          pstrb_d  = bus.cmd_write ? bus.cmd_strb  : '0;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        // Completion is checked first so pready on the last allowed cycle wins.
        if (bus.pready) begin
          state_d     = ST_RESP;
          rsp_err_d   = bus.pslverr;
          rsp_rdata_d = (!pwrite_q && !bus.pslverr) ? bus.prdata : '0;
        end else if (expired) begin
          state_d     = ST_RESP;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Control outputs are decoded from the next state so they leave a flop.
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
    rsp_valid_d = (state_d == ST_RESP);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      pstrb_q     <= pstrb_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a small 16-word register-map slave.
module tb_apb_cmd_master;

  logic pclk;
  logic prstn;
  int   checks;
  int   errors;

  apb_cmd_master_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  apb_cmd_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk  (pclk),
    .prstn (prstn),
    .bus   (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Register-map slave: word registers, byte strobes honoured on completed writes.
  logic [31:0] regs [16];
  initial for (int i = 0; i < 16; i++) regs[i] = 32'h0;
  assign bus.prdata = regs[bus.paddr[5:2]];
  always @(posedge pclk) begin
    if (bus.psel && bus.penable && bus.pready && bus.pwrite) begin
      for (int b = 0; b < 4; b++)
        if (bus.pstrb[b]) regs[bus.paddr[5:2]][b*8 +: 8] <= bus.pwdata[b*8 +: 8];
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Presents a command and returns just after the accepting edge (SETUP cycle).
  task automatic send_cmd(input logic wr, input logic [11:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb);
    int n;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.cmd_ready) begin
      errors++;
      $display("FAIL accept_wait: cmd_ready got %b required 1", bus.cmd_ready);
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    prstn = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready, bus.rsp_err, bus.pwrite} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: psel/pen/rv/crdy/err/pwr got %b required 000000",
               {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready, bus.rsp_err, bus.pwrite});
    end
    checks++;
    if ({bus.paddr, bus.pwdata, bus.pstrb, bus.rsp_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: paddr %h pwdata %h pstrb %h rdata %h required all 0",
               bus.paddr, bus.pwdata, bus.pstrb, bus.rsp_rdata);
    end
    prstn = 1'b1;
    tick();
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: cmd_ready got %b required 1", bus.cmd_ready);
    end
  endtask

  task automatic test_write();
    bus.pready = 1'b1;
    send_cmd(1'b1, 12'h308, 32'h0012_0034, 4'hF);
    checks++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.pstrb, bus.paddr, bus.pwdata} !==
        {1'b1, 1'b0, 1'b1, 4'hF, 12'h308, 32'h0012_0034}) begin
      errors++;
      $display("FAIL wr_setup: sel %b en %b wr %b strb %h addr %h wdata %h required 1 0 1 f 308 00120034",
               bus.psel, bus.penable, bus.pwrite, bus.pstrb, bus.paddr, bus.pwdata);
    end
    tick();
    checks++;
    if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) begin
      errors++;
      $display("FAIL wr_access: sel/en/rv got %b required 110", {bus.psel, bus.penable, bus.rsp_valid});
    end
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.psel, bus.penable, bus.cmd_ready, bus.rsp_rdata} !==
        {5'b10000, 32'h0}) begin
      errors++;
      $display("FAIL wr_resp: rv %b err %b sel %b en %b crdy %b rdata %h required 1 0 0 0 0 0",
               bus.rsp_valid, bus.rsp_err, bus.psel, bus.penable, bus.cmd_ready, bus.rsp_rdata);
    end
    drain();
    checks++;
    if ({bus.rsp_valid, bus.cmd_ready, bus.paddr, bus.pwrite} !== {1'b0, 1'b1, 12'h308, 1'b1}) begin
      errors++;
      $display("FAIL wr_idle: rv %b crdy %b paddr %h pwrite %b required 0 1 308 1",
               bus.rsp_valid, bus.cmd_ready, bus.paddr, bus.pwrite);
    end
  endtask

  task automatic test_read();
    send_cmd(1'b0, 12'h308, 32'hFFFF_FFFF, 4'hF);
    checks++;
    if ({bus.pwrite, bus.pstrb, bus.pwdata} !== {1'b0, 4'h0, 32'h0}) begin
      errors++;
      $display("FAIL rd_setup: pwrite %b pstrb %h pwdata %h required 0 0 0",
               bus.pwrite, bus.pstrb, bus.pwdata);
    end
    tick();
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b10, 32'h0012_0034}) begin
      errors++;
      $display("FAIL rd_resp: rv %b err %b rdata %h required 1 0 00120034",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    drain();
  endtask

  task automatic test_wait_states();
    int pen_cycles;
    bus.pready = 1'b0;
    send_cmd(1'b1, 12'h30C, 32'hA5A5_0000, 4'h3);
    tick();
    pen_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.pready = 1'b1;
      checks++;
      if ({bus.psel, bus.penable, bus.paddr, bus.pstrb} !== {2'b11, 12'h30C, 4'h3}) begin
        errors++;
        $display("FAIL wait_hold[%0d]: sel %b en %b addr %h strb %h required 1 1 30c 3",
                 i, bus.psel, bus.penable, bus.paddr, bus.pstrb);
      end
      if (bus.penable) pen_cycles++;
      tick();
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.penable} !== 3'b100 || pen_cycles != 4) begin
      errors++;
      $display("FAIL wait_resp: rv %b err %b en %b pen_cycles %0d required 1 0 0 4",
               bus.rsp_valid, bus.rsp_err, bus.penable, pen_cycles);
    end
    drain();
  endtask

  task automatic test_timeout();
    int n;
    bus.pready = 1'b0;
    send_cmd(1'b0, 12'h308, 32'h0, 4'h0);
    tick();
    n = 0;
    while (bus.penable && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL to_cycles: access cycles got %0d required 16", n);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.psel, bus.rsp_rdata} !== {3'b110, 32'h0}) begin
      errors++;
      $display("FAIL to_resp: rv %b err %b sel %b rdata %h required 1 1 0 0",
               bus.rsp_valid, bus.rsp_err, bus.psel, bus.rsp_rdata);
    end
    drain();
    send_cmd(1'b1, 12'h310, 32'hDEAD_BEEF, 4'hF);
    tick();
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) bus.pready = 1'b1;
      tick();
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.psel} !== 3'b100) begin
      errors++;
      $display("FAIL to_edge: rv %b err %b sel %b required 1 0 0",
               bus.rsp_valid, bus.rsp_err, bus.psel);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic bad;
    bus.pready = 1'b1;
    send_cmd(1'b0, 12'h310, 32'h0, 4'h0);
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 12'h310;
    bus.cmd_valid = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL b2b_rd1: rv %b err %b rdata %h required 1 0 deadbeef",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.cmd_ready || bus.psel || !bus.rsp_valid || bus.rsp_rdata !== 32'hDEAD_BEEF) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL b2b_stall: busy-hold violated got 1 required 0");
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.psel} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_idle: crdy %b rv %b sel %b required 1 0 0",
               bus.cmd_ready, bus.rsp_valid, bus.psel);
    end
    tick();
    bus.cmd_valid = 1'b0;
    bus.pslverr   = 1'b1;
    checks++;
    if ({bus.psel, bus.penable, bus.paddr, bus.pwrite} !== {2'b10, 12'h310, 1'b0}) begin
      errors++;
      $display("FAIL b2b_accept2: sel %b en %b addr %h wr %b required 1 0 310 0",
               bus.psel, bus.penable, bus.paddr, bus.pwrite);
    end
    tick();
    tick();
    bus.pslverr = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b11, 32'h0}) begin
      errors++;
      $display("FAIL slverr: rv %b err %b rdata %h required 1 1 0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bus.pready = 1'b0;
    send_cmd(1'b1, 12'h318, 32'h5555_5555, 4'hF);
    tick();
    tick();
    checks++;
    if (bus.penable !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: penable got %b required 1", bus.penable);
    end
    #2 prstn = 1'b0;
    #1;
    checks++;
    if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready} !== 4'b0) begin
      errors++;
      $display("FAIL rst_async: sel/en/rv/crdy got %b required 0000",
               {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready});
    end
    tick();
    prstn = 1'b1;
    bus.pready = 1'b1;
    tick();
    send_cmd(1'b1, 12'h318, 32'h1122_3344, 4'hF);
    tick();
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_err} !== 2'b10) begin
      errors++;
      $display("FAIL rst_after_wr: rv %b err %b required 1 0", bus.rsp_valid, bus.rsp_err);
    end
    drain();
    send_cmd(1'b0, 12'h318, 32'h0, 4'h0);
    tick();
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 32'h1122_3344}) begin
      errors++;
      $display("FAIL rst_after_rd: rv %b rdata %h required 1 11223344", bus.rsp_valid, bus.rsp_rdata);
    end
    drain();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    prstn         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.rsp_ready = 1'b0;
    bus.pready    = 1'b1;
    bus.pslverr   = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_wait_states();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
